run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: core reset hold length in cycles; legal range >= 1.
REQ-002 Parameter MAX_CYCLES, default 40: run-cycle limit; 0 disables the limit; legal range < 2**CNT_W.
REQ-003 Parameter CNT_W, default 16: width of the cycle counter.
REQ-004 Parameter PC_W, default 32: width of the PC and break-address inputs.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-low reset.
REQ-007 Port start, input, 1: launch request, sampled only in IDLE and DONE.
REQ-008 Port halt_req, input, 1: core ecall/ebreak halt request, sampled only in RUN.
REQ-009 Port pc, input, PC_W: current core PC.
REQ-010 Port break_pc, input, PC_W: breakpoint address.
REQ-011 Port core_rst, output, 1: active-high reset to the core.
REQ-012 Port run, output, 1: core clock-enable; 1 only in RUN.
REQ-013 Port done, output, 1: run finished; held until the next launch.
REQ-014 Port timeout, output, 1: run ended on the cycle limit.
REQ-015 Port bp_hit, output, 1: run ended on the PC breakpoint.
REQ-016 Port cycle_count, output, CNT_W: number of RUN cycles in the current or last run.

Function
REQ-017 The FSM SHALL have four states: IDLE, RESET, RUN and DONE; all outputs SHALL be registered.
REQ-018 IDLE: core_rst=1, run=0; start=1 SHALL move the FSM to RESET.
REQ-019 Launch from IDLE or DONE SHALL clear cycle_count, done, timeout and bp_hit on the same edge that enters RESET.
REQ-020 RESET: core_rst=1 for exactly RST_CYCLES cycles, then RUN; start SHALL be ignored.
REQ-021 RUN: core_rst=0, run=1; cycle_count SHALL increment by 1 on every RUN cycle, including the exit cycle.
REQ-022 RUN exit priority SHALL be halt_req, then PC breakpoint (REQ-030), then limit.
- Limit condition: MAX_CYCLES != 0 and cycle_count+1 == MAX_CYCLES.
- Exit goes to DONE and sets exactly one of: nothing (halt_req), bp_hit, or timeout.
REQ-023 When halt_req and the limit condition occur in the same cycle, the FSM SHALL set timeout=0 and cycle_count=MAX_CYCLES.
REQ-024 With MAX_CYCLES=0, cycle_count SHALL saturate at all-ones and never wrap.
REQ-025 DONE: run=0, core_rst=0 (core state preserved for inspection), done=1; flags and cycle_count SHALL be held.
REQ-026 start=1 in DONE SHALL relaunch per REQ-019.
REQ-027 halt_req and pc SHALL be ignored outside RUN.

Reset
REQ-028 rst=0 at a rising edge SHALL, from any state including mid-RUN, force:
- state IDLE
- core_rst=1, run=0, done=0, timeout=0, bp_hit=0
- cycle_count=0 and the internal reset counter cleared
REQ-029 rst=0 SHALL take priority over start, halt_req and every exit condition.

Configuration
REQ-030 Macro RUN_CTRL_PC_BREAK_EN, when defined, SHALL enable the breakpoint exit: in RUN, pc==break_pc exits to DONE with bp_hit=1.
REQ-031 Without RUN_CTRL_PC_BREAK_EN:
- bp_hit SHALL be constant 0.
- pc and break_pc SHALL remain as ports but be ignored, with no comparator logic.

Verification
REQ-032 Bench SHALL cover reset: rst=0 for 2 cycles -> core_rst=1, run=0, done=0, timeout=0, bp_hit=0, cycle_count=0.
REQ-033 Bench SHALL cover timeout: start pulse, no halt_req -> core_rst=1 for 2 cycles, then run=1 for 40 cycles, then done=1, timeout=1, cycle_count=40.
REQ-034 Bench SHALL cover halt: halt_req=1 on the 10th RUN cycle -> next cycle done=1, timeout=0, cycle_count=10, run=0.
REQ-035 Bench SHALL cover simultaneous events: halt_req=1 on the 40th RUN cycle -> done=1, timeout=0, cycle_count=40.
REQ-036 Bench SHALL cover reset mid-run: rst=0 at cycle_count=17 -> IDLE with reset values; subsequent start -> fresh run from cycle_count=0.
REQ-037 Bench SHALL cover the breakpoint with the macro defined: break_pc=0x00000020, pc reaches 0x20 on RUN cycle 8 -> done=1, bp_hit=1, cycle_count=8.
- Same stimulus with the macro undefined -> bp_hit=0, run ends on timeout at cycle_count=40.

Source files
------------

// File: rtl/run_ctrl.sv
// Core run controller: holds the core in reset, runs it until halt, breakpoint
// or cycle limit, then freezes it for inspection. Breakpoint exit needs RUN_CTRL_PC_BREAK_EN.
module run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 16,
  parameter int PC_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  break_pc,
  output logic             core_rst,
  output logic             run,
  output logic             done,
  output logic             timeout,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  // state | meaning
  // IDLE  | core held in reset, waiting for start
  // RESET | core reset asserted for RST_CYCLES cycles
  // RUN   | core clock enabled, counting cycles
  // DONE  | core frozen out of reset, result flags held
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LOAD = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_CYCLES);

  logic [1:0]       state;
  logic [RW-1:0]    rst_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             limit_hit;
  logic             bp_cond;
  logic             bp_q;
  logic             run_exit;

  // Saturating increment; only matters when the limit is disabled.
  assign cnt_next  = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
  assign limit_hit = (MAX_CYCLES != 0) && (cnt_next == LIMIT);

`ifdef RUN_CTRL_PC_BREAK_EN
  assign bp_cond = (pc == break_pc);
  assign bp_hit  = bp_q;
`else
  logic unused_bp;
  assign bp_cond   = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, break_pc, bp_q};
`endif

  assign run_exit = halt_req | bp_cond | limit_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      core_rst    <= 1'b1;
      run         <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      bp_q        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RESET;
            rst_cnt     <= RST_LOAD;
            core_rst    <= 1'b1;
            run         <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            bp_q        <= 1'b0;
            cycle_count <= '0;
          end
        end
        S_RESET: begin
          if (rst_cnt == '0) begin
            state    <= S_RUN;
            core_rst <= 1'b0;
            run      <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        S_RUN: begin
          cycle_count <= cnt_next;
          if (run_exit) begin
            state <= S_DONE;
            run   <= 1'b0;
            done  <= 1'b1;
            // halt_req outranks both flags, breakpoint outranks the limit
            if (!halt_req) begin
              if (bp_cond) bp_q    <= 1'b1;
              else         timeout <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: reset, timeout, halt, halt-at-limit, mid-run
// reset, and the breakpoint exit (expectation follows RUN_CTRL_PC_BREAK_EN).
module tb_run_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] break_pc;
  logic        core_rst;
  logic        run;
  logic        done;
  logic        timeout;
  logic        bp_hit;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .pc          (pc),
    .break_pc    (break_pc),
    .core_rst    (core_rst),
    .run         (run),
    .done        (done),
    .timeout     (timeout),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_launch_cnt"},  32'(cycle_count), 0);
    chk({tag, "_launch_done"}, 32'(done), 0);
    chk({tag, "_launch_to"},   32'(timeout), 0);
    chk({tag, "_launch_crst"}, 32'(core_rst), 1);
  endtask

  // Counts samples with core_rst high; start held high to show it is ignored.
  task automatic wait_reset(input string tag);
    int n;
    n = 0;
    start = 1'b1;
    while (core_rst && n < 50) begin
      n++;
      step();
    end
    start = 1'b0;
    chk({tag, "_rst_cycles"}, 32'(n), 2);
    chk({tag, "_run_on"}, 32'(run), 1);
  endtask

  // RUN cycle i is the sample window after the i-th edge into/within RUN.
  task automatic run_to_done(input int halt_at, output int runs);
    runs = 0;
    for (int i = 1; i <= 200; i++) begin
      if (!run) break;
      runs     = i;
      pc       = 32'(i * 4);
      halt_req = (i == halt_at);
      step();
      halt_req = 1'b0;
    end
    chk("run_ended", 32'(run), 0);
  endtask

  int runs;
  int budget;

  initial begin
    rst = 1'b0; start = 1'b0; halt_req = 1'b0;
    pc = '0; break_pc = 32'hFFFF_FFF0;

    step(); step();
    chk("rst_core_rst", 32'(core_rst), 1);
    chk("rst_run",      32'(run), 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_timeout",  32'(timeout), 0);
    chk("rst_bp_hit",   32'(bp_hit), 0);
    chk("rst_count",    32'(cycle_count), 0);
    rst = 1'b1;
    step();
    chk("idle_core_rst", 32'(core_rst), 1);

    // timeout after 40 RUN cycles
    launch("to");
    wait_reset("to");
    run_to_done(0, runs);
    chk("to_runs",    32'(runs), 40);
    chk("to_done",    32'(done), 1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_bp",      32'(bp_hit), 0);
    chk("to_count",   32'(cycle_count), 40);
    chk("to_core_rst", 32'(core_rst), 0);

    // halt_req outside RUN has no effect
    halt_req = 1'b1;
    step(); step();
    halt_req = 1'b0;
    chk("done_hold",  32'(done), 1);
    chk("done_count", 32'(cycle_count), 40);

    // halt on RUN cycle 10
    launch("halt");
    wait_reset("halt");
    run_to_done(10, runs);
    chk("halt_count",   32'(cycle_count), 10);
    chk("halt_done",    32'(done), 1);
    chk("halt_timeout", 32'(timeout), 0);

    // halt coinciding with the limit
    launch("sim");
    wait_reset("sim");
    run_to_done(40, runs);
    chk("sim_count",   32'(cycle_count), 40);
    chk("sim_done",    32'(done), 1);
    chk("sim_timeout", 32'(timeout), 0);

    // reset mid-run at cycle_count 17
    launch("mid");
    wait_reset("mid");
    budget = 0;
    while (cycle_count != 16'd17 && budget < 100) begin
      budget++;
      step();
    end
    chk("mid_reached17", 32'(cycle_count), 17);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_core_rst", 32'(core_rst), 1);
    chk("mid_run",      32'(run), 0);
    chk("mid_done",     32'(done), 0);
    chk("mid_count",    32'(cycle_count), 0);
    step();
    chk("mid_idle_run", 32'(run), 0);
    launch("fresh");
    wait_reset("fresh");
    run_to_done(0, runs);
    chk("fresh_count",   32'(cycle_count), 40);
    chk("fresh_timeout", 32'(timeout), 1);

    // breakpoint at 0x20 reached on RUN cycle 8
    break_pc = 32'h0000_0020;
    launch("bp");
    wait_reset("bp");
    run_to_done(0, runs);
`ifdef RUN_CTRL_PC_BREAK_EN
    chk("bp_count",   32'(cycle_count), 8);
    chk("bp_hit",     32'(bp_hit), 1);
    chk("bp_timeout", 32'(timeout), 0);
`else
    chk("bp_count",   32'(cycle_count), 40);
    chk("bp_hit",     32'(bp_hit), 0);
    chk("bp_timeout", 32'(timeout), 1);
`endif
    chk("bp_done", 32'(done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
